// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared sizing helpers for the PDM amplitude meter
package pdm_pkg;

   // Ceiling log2; clog2(1) is 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Bits needed to hold 0..max_value, never less than one.
   function automatic int width_for(input int max_value);
      int w;
      w = clog2(max_value + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // Window depth N.
   function automatic int win_size(input int log2_win);
      return 1 << log2_win;
   endfunction

   // Mid-scale N/2, the zero-amplitude point of the ones count.
   function automatic int mid_scale(input int log2_win);
      return 1 << (log2_win - 1);
   endfunction

   // Ones count spans 0..N inclusive, so it needs one bit more than the pointer.
   function automatic int cnt_w(input int log2_win);
      return log2_win + 1;
   endfunction

   // Offset from mid-scale spans 0..N/2.
   function automatic int amp_w(input int log2_win);
      return log2_win;
   endfunction

endpackage

// File: rtl/pdm_amp_meter_if.sv
// rtl/pdm_amp_meter_if.sv - sample input and meter output bundle
interface pdm_amp_meter_if
   import pdm_pkg::*;
#(
   parameter int LOG2_WIN = 7
);
   logic                          sample_en_i;
   logic                          M_DATA;
   logic                          clear_peak_i;
   logic [cnt_w(LOG2_WIN)-1:0]    count_o;
   logic [amp_w(LOG2_WIN)-1:0]    amp_o;
   logic [amp_w(LOG2_WIN)-1:0]    peak_o;
   logic                          valid_o;
   logic                          filled_o;

   modport master (
      output sample_en_i, M_DATA, clear_peak_i,
      input  count_o, amp_o, peak_o, valid_o, filled_o
   );

   modport slave (
      input  sample_en_i, M_DATA, clear_peak_i,
      output count_o, amp_o, peak_o, valid_o, filled_o
   );
endinterface

// File: rtl/pdm_window_counter.sv
// rtl/pdm_window_counter.sv - sliding-window ones counter with fill tracking
module pdm_window_counter
   import pdm_pkg::*;
#(
   parameter int LOG2_WIN = 7
) (
   input  logic              clk,
   input  logic              rst_ni,
   input  logic              sample_en_i,
   input  logic              data_i,
   output logic [LOG2_WIN:0] count_o,
   output logic [LOG2_WIN:0] count_next_o,
   output logic              filled_o,
   output logic              filled_next_o
);
   localparam int N     = win_size(LOG2_WIN);
   localparam int CNT_W = cnt_w(LOG2_WIN);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(N);

   logic [N-1:0]        win_q,   win_d;
   logic [LOG2_WIN-1:0] wptr_q,  wptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    fill_q,  fill_d;
   logic                old_bit;

   // Replace the oldest bit with the new one and adjust the count by the difference.
   always_comb begin
      win_d   = win_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      fill_d  = fill_q;
      old_bit = win_q[wptr_q];
      if (sample_en_i) begin
         win_d[wptr_q] = data_i;
         wptr_d        = wptr_q + LOG2_WIN'(1);
         count_d       = count_q - CNT_W'(old_bit) + CNT_W'(data_i);
         if (fill_q != FULL) begin
            fill_d = fill_q + CNT_W'(1);
         end
      end
   end

   // Window state; reset discards all history.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         win_q   <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         fill_q  <= '0;
      end else begin
         win_q   <= win_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         fill_q  <= fill_d;
      end
   end

   assign count_o       = count_q;
   assign count_next_o  = count_d;
   assign filled_o      = (fill_q == FULL);
   assign filled_next_o = (fill_d == FULL);
endmodule

// File: rtl/pdm_amp_meter.sv
// rtl/pdm_amp_meter.sv - PDM amplitude meter with decimated output and peak hold
module pdm_amp_meter
   import pdm_pkg::*;
#(
   parameter int LOG2_WIN    = 7,
   parameter int DECIM       = 4,
   parameter int HOLD        = 64,
   parameter int DECAY_SHIFT = 3
) (
   input  logic            M_CLK,
   input  logic            rst_ni,
   pdm_amp_meter_if.slave  bus
);
   localparam int CNT_W  = cnt_w(LOG2_WIN);
   localparam int AMP_W  = amp_w(LOG2_WIN);
   localparam int DEC_W  = width_for(DECIM - 1);
   localparam int HOLD_W = width_for(HOLD);
   localparam logic [CNT_W-1:0]  MID       = CNT_W'(mid_scale(LOG2_WIN));
   localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD);

   logic [CNT_W-1:0]  win_count;
   logic [CNT_W-1:0]  win_count_next;
   logic              win_filled;
   logic              win_filled_next;
   logic [AMP_W-1:0]  off_next;
   logic              accept;
   logic              tick;
   logic [AMP_W-1:0]  step;
   logic [AMP_W-1:0]  decayed;

   logic [DEC_W-1:0]  dec_q,   dec_d;
   logic [AMP_W-1:0]  amp_q,   amp_d;
   logic              valid_q, valid_d;
   logic [AMP_W-1:0]  peak_q,  peak_d;
   logic [HOLD_W-1:0] hold_q,  hold_d;

   pdm_window_counter #(
      .LOG2_WIN (LOG2_WIN)
   ) u_window (
      .clk           (M_CLK),
      .rst_ni        (rst_ni),
      .sample_en_i   (bus.sample_en_i),
      .data_i        (bus.M_DATA),
      .count_o       (win_count),
      .count_next_o  (win_count_next),
      .filled_o      (win_filled),
      .filled_next_o (win_filled_next)
   );

   // Only samples that leave the window full feed the decimator and the peak meter.
   assign accept = bus.sample_en_i && win_filled_next;

   // Absolute distance of the post-sample count from mid-scale.
   always_comb begin
      off_next = '0;
      if (win_count_next >= MID) begin
         off_next = AMP_W'(win_count_next - MID);
      end else begin
         off_next = AMP_W'(MID - win_count_next);
      end
   end

   // Decimation tick, latched amplitude and peak-hold/decay next state.
   always_comb begin
      dec_d   = dec_q;
      amp_d   = amp_q;
      valid_d = 1'b0;
      peak_d  = peak_q;
      hold_d  = hold_q;
      tick    = 1'b0;
      step    = '0;
      decayed = '0;
      if (accept) begin
         if (dec_q == DEC_LAST) begin
            tick  = 1'b1;
            dec_d = '0;
         end else begin
            dec_d = dec_q + DEC_W'(1);
         end
      end
      if (tick) begin
         amp_d   = off_next;
         valid_d = 1'b1;
      end
      if (bus.clear_peak_i) begin
         peak_d = '0;
         hold_d = '0;
      end else if (accept) begin
         if (off_next >= peak_q) begin
            peak_d = off_next;
            hold_d = HOLD_LOAD;
         end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
         end else if (peak_q != '0) begin
            // peak is strictly above off_next here, so the step never underflows
            step = peak_q >> DECAY_SHIFT;
            if (step == '0) begin
               step = AMP_W'(1);
            end
            decayed = peak_q - step;
            peak_d  = (decayed > off_next) ? decayed : off_next;
         end
      end
   end

   // Output and meter registers.
   always_ff @(posedge M_CLK or negedge rst_ni) begin
      if (!rst_ni) begin
         dec_q   <= '0;
         amp_q   <= '0;
         valid_q <= 1'b0;
         peak_q  <= '0;
         hold_q  <= '0;
      end else begin
         dec_q   <= dec_d;
         amp_q   <= amp_d;
         valid_q <= valid_d;
         peak_q  <= peak_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.count_o  = win_count;
   assign bus.amp_o    = amp_q;
   assign bus.peak_o   = peak_q;
   assign bus.valid_o  = valid_q;
   assign bus.filled_o = win_filled;
endmodule
